// File: rtl/ez_bist_pkg.sv
// Shared types and constants for the Ez BIST tester: FSM states, datapath widths,
// MISR polynomial and LFSR taps.
package ez_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned LFSR_W = 6;
  localparam int unsigned RSP_W  = 3;
  localparam int unsigned SIG_W  = 16;

  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  // x^6 + x^5 + 1, Fibonacci form
  localparam int unsigned LFSR_TAP_A = 5;
  localparam int unsigned LFSR_TAP_B = 4;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/ez_misr.sv
// Multiple-input signature register compacting the Ez block responses.
// Clear takes priority over enable.
module ez_misr
  import ez_bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = MISR_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [RSP_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0}
           ^ (sig[SIG_W-1] ? POLY : '0)
           ^ {{(SIG_W-RSP_W){1'b0}}, din};
    end
  end

endmodule

// File: rtl/ez_bist_tester.sv
// BIST driver/checker for the Ez logic block: LFSR stimulus, latency-aligned MISR
// capture, golden compare. Optional external seed port under EZ_BIST_EXT_SEED_EN.
module ez_bist_tester
  import ez_bist_pkg::*;
#(
  parameter int unsigned       NUM_PAT    = 63,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 6'h01,
  parameter int unsigned       RESP_LAT   = 0,
  parameter logic [SIG_W-1:0]  GOLDEN_SIG = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef EZ_BIST_EXT_SEED_EN
  input  logic [LFSR_W-1:0] seed_i,
`endif
  output logic [LFSR_W-1:0] pat_o,
  output logic              pat_vld_o,
  input  logic [RSP_W-1:0]  resp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [SIG_W-1:0]  sig_o
);

  localparam logic [LFSR_W-1:0] LAST_PAT   = LFSR_W'(NUM_PAT);
  localparam logic [1:0]        DRAIN_LAST = (RESP_LAT == 0) ? 2'd0 : 2'(RESP_LAT - 1);

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] pat_cnt;
  logic [1:0]        drn_cnt;
  logic [LFSR_W-1:0] start_seed;
  logic [LFSR_W-1:0] reload_seed;
  logic              accept;
  logic              cap;

  assign accept = start && (state == IDLE || state == DONE);

`ifdef EZ_BIST_EXT_SEED_EN
  logic [LFSR_W-1:0] seed_q;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign start_seed  = (seed_i == '0) ? LFSR_W'(1) : seed_i;
  assign reload_seed = seed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q <= LFSR_SEED;
    end else if (accept) begin
      seed_q <= start_seed;
    end
  end
`else
  assign start_seed  = LFSR_SEED;
  assign reload_seed = LFSR_SEED;
`endif

  // Capture strobe is pat_vld_o delayed by the response latency of the block.
  generate
    if (RESP_LAT == 0) begin : g_nodly
      assign cap = pat_vld_o;
    end else begin : g_dly
      logic [RESP_LAT-1:0] vld_dly;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_dly <= '0;
        end else begin
          vld_dly[0] <= pat_vld_o;
          for (int unsigned i = 1; i < RESP_LAT; i++) begin
            vld_dly[i] <= vld_dly[i-1];
          end
        end
      end

      assign cap = vld_dly[RESP_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      pat_o     <= '0;
      pat_vld_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      pat_cnt   <= '0;
      drn_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            pat_o     <= start_seed;
            lfsr      <= lfsr_next(start_seed);
            pat_vld_o <= 1'b1;
            busy_o    <= 1'b1;
            done_o    <= 1'b0;
            pat_cnt   <= LFSR_W'(1);
          end
        end
        RUN: begin
          if (pat_cnt == LAST_PAT) begin
            pat_vld_o <= 1'b0;
            if (RESP_LAT == 0) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              lfsr   <= reload_seed;
            end else begin
              state   <= DRAIN;
              drn_cnt <= '0;
            end
          end else begin
            pat_o   <= lfsr;
            lfsr    <= lfsr_next(lfsr);
            pat_cnt <= pat_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drn_cnt == DRAIN_LAST) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            lfsr   <= reload_seed;
          end else begin
            drn_cnt <= drn_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ez_misr #(
    .POLY(MISR_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (cap),
    .din (resp_i),
    .sig (sig_o)
  );

  // The last capture lands on the same edge that raises done_o, so the compare
  // is taken from the live signature rather than registered a cycle later.
  assign pass_o = done_o && (sig_o == GOLDEN_SIG);

endmodule
